// File: rtl/cv_sweep_gen_if.sv
// Control/status bundle between the sweep controller and cv_sweep_gen.
interface cv_sweep_gen_if #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DIV_W = 16,
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic             abort;
    logic [DW-1:0]    e_start;
    logic [DW-1:0]    e_vertex1;
    logic [DW-1:0]    e_vertex2;
    logic [DW-1:0]    step;
    logic [DIV_W-1:0] step_div;
    logic [CNT_W-1:0] n_cycles;
    logic [DW-1:0]    dac_code;
    logic             code_update;
    logic             busy;
    logic             done;
    logic             dir_up;
    logic [CNT_W-1:0] cycle_cnt;

    // Controller side: issues commands and parameters, observes the sweep.
    modport master (
        output start, abort, e_start, e_vertex1, e_vertex2, step, step_div, n_cycles,
        input  dac_code, code_update, busy, done, dir_up, cycle_cnt
    );

    // Generator side.
    modport slave (
        input  start, abort, e_start, e_vertex1, e_vertex2, step, step_div, n_cycles,
        output dac_code, code_update, busy, done, dir_up, cycle_cnt
    );
endinterface

// File: rtl/cv_sweep_gen.sv
// Triangular start -> vertex1 -> vertex2 -> start DAC code sweep for cyclic voltammetry.
module cv_sweep_gen #(
    parameter int unsigned   DW        = 16,
    parameter int unsigned   DIV_W     = 16,
    parameter int unsigned   CNT_W     = 8,
    parameter logic [DW-1:0] IDLE_CODE = DW'(16'h8000)
) (
    input logic           clk,
    input logic           RST,
    cv_sweep_gen_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_SEG1, S_SEG2, S_SEG3} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DW-1:0]    code_q, code_d;
    logic             upd_q, upd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Parameters captured at start; step/div/n already have the 0 -> 1 rule applied.
    logic [DW-1:0]    start_q, start_d;
    logic [DW-1:0]    v1_q, v1_d;
    logic [DW-1:0]    v2_q, v2_d;
    logic [DW-1:0]    step_q, step_d;
    logic [DIV_W-1:0] div_max_q, div_max_d;
    logic [CNT_W-1:0] n_q, n_d;

    logic [DW-1:0]    tgt_c;
    logic             up_c;
    logic [DW:0]      sum_c;
    logic [DW-1:0]    diff_c;
    logic [DW-1:0]    next_code_c;
    logic             tick_c;
    logic [CNT_W-1:0] cnt_inc_c;

    // Saturating step toward the current segment target.
    always_comb begin
        unique case (state_q)
            S_SEG1:  tgt_c = v1_q;
            S_SEG2:  tgt_c = v2_q;
            default: tgt_c = start_q;
        endcase
        up_c      = tgt_c > code_q;
        sum_c     = {1'b0, code_q} + {1'b0, step_q};
        diff_c    = code_q - tgt_c;
        tick_c    = div_q == div_max_q;
        cnt_inc_c = cnt_q + CNT_W'(1);
        if (up_c) begin
            next_code_c = (sum_c >= {1'b0, tgt_c}) ? tgt_c : sum_c[DW-1:0];
        end else begin
            next_code_c = (diff_c <= step_q) ? tgt_c : code_q - step_q;
        end
    end

    // Sequencer: start/abort handling, step divider, segment and cycle advance.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        code_d    = code_q;
        upd_d     = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        start_d   = start_q;
        v1_d      = v1_q;
        v2_d      = v2_q;
        step_d    = step_q;
        div_max_d = div_max_q;
        n_d       = n_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    start_d   = bus.e_start;
                    v1_d      = bus.e_vertex1;
                    v2_d      = bus.e_vertex2;
                    step_d    = (bus.step == '0) ? DW'(1) : bus.step;
                    div_max_d = (bus.step_div == '0) ? '0 : bus.step_div - DIV_W'(1);
                    n_d       = (bus.n_cycles == '0) ? CNT_W'(1) : bus.n_cycles;
                    code_d    = bus.e_start;
                    upd_d     = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    div_d     = '0;
                    state_d   = S_SEG1;
                end
            end
            default: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    code_d  = start_q;
                    upd_d   = start_q != code_q;
                    busy_d  = 1'b0;
                    div_d   = '0;
                end else begin
                    div_d = tick_c ? '0 : div_q + DIV_W'(1);
                    if (tick_c) begin
                        dir_d  = up_c;
                        code_d = next_code_c;
                        upd_d  = next_code_c != code_q;
                        if (next_code_c == tgt_c) begin
                            unique case (state_q)
                                S_SEG1: state_d = S_SEG2;
                                S_SEG2: state_d = S_SEG3;
                                default: begin
                                    cnt_d = cnt_inc_c;
                                    if (cnt_inc_c == n_q) begin
                                        state_d = S_IDLE;
                                        busy_d  = 1'b0;
                                        done_d  = 1'b1;
                                    end else begin
                                        state_d = S_SEG1;
                                    end
                                end
                            endcase
                        end
                    end
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            code_q    <= IDLE_CODE;
            upd_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dir_q     <= 1'b0;
            cnt_q     <= '0;
            start_q   <= '0;
            v1_q      <= '0;
            v2_q      <= '0;
            step_q    <= '0;
            div_max_q <= '0;
            n_q       <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            code_q    <= code_d;
            upd_q     <= upd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            step_q    <= step_d;
            div_max_q <= div_max_d;
            n_q       <= n_d;
        end
    end

    assign bus.dac_code    = code_q;
    assign bus.code_update = upd_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.dir_up      = dir_q;
    assign bus.cycle_cnt   = cnt_q;

endmodule
